serial_alu_engine: RTL

Bit-serial ALU datapath controller. Accepts a 3-bit ALU command and two WIDTH-bit operands, then drives one one-bit ALU slice LSB-first, one bit per clock, carrying the carry between cycles. It shifts each slice result into a result register and produces the final WIDTH-bit result plus carryout, overflow and zero flags. It is the stage that feeds the single-bit slice and consumes its sum/carry outputs, trading latency for area against a ripple array.

---
 rtl/alu_pkg.sv | 35 +++
 rtl/serial_alu_slice.sv | 36 +++
 rtl/serial_alu_engine.sv | 116 +++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared opcodes, FSM encoding and helpers for the bit-serial ALU.
// Imported by the engine and its one-bit slice.
package alu_pkg;

  localparam logic [2:0] ADD_ALU  = 3'd0;
  localparam logic [2:0] SUB_ALU  = 3'd1;
  localparam logic [2:0] XOR_ALU  = 3'd2;
  localparam logic [2:0] SLT_ALU  = 3'd3;
  localparam logic [2:0] AND_ALU  = 3'd4;
  localparam logic [2:0] NAND_ALU = 3'd5;
  localparam logic [2:0] NOR_ALU  = 3'd6;
  localparam logic [2:0] OR_ALU   = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic is_arith(
    input logic [2:0] c
  );
    return (c == ADD_ALU) ||
           (c == SUB_ALU) ||
           (c == SLT_ALU);
  endfunction

  function automatic logic is_sub(
    input logic [2:0] c
  );
    return (c == SUB_ALU) ||
           (c == SLT_ALU);
  endfunction

endpackage

// File: rtl/serial_alu_slice.sv
// Combinational one-bit ALU slice.
// Subtract-type ops invert b here; the carry-in supplies the +1.
module serial_alu_slice
  import alu_pkg::*;
(
  input  logic       a,
  input  logic       b,
  input  logic       carryin,
  input  logic [2:0] command,
  output logic       result,
  output logic       carryout
);

  logic b_eff;

  assign b_eff = b ^ is_sub(command);

  always_comb begin
    result   = 1'b0;
    carryout = 1'b0;
    unique case (1'b1)
      is_arith(command): begin
        result   = a ^ b_eff ^ carryin;
        carryout = (a & b_eff) |
                   (carryin & (a ^ b_eff));
      end
      (command == XOR_ALU):  result = a ^ b;
      (command == AND_ALU):  result = a & b;
      (command == NAND_ALU): result = ~(a & b);
      (command == NOR_ALU):  result = ~(a | b);
      (command == OR_ALU):   result = a | b;
      default: result = 1'b0;
    endcase
  end

endmodule

// File: rtl/serial_alu_engine.sv
// Bit-serial ALU engine: feeds one slice LSB-first, one bit per clock,
// and assembles the WIDTH-bit result plus carry/overflow/zero flags.
module serial_alu_engine
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       command,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carryout,
  output logic             overflow,
  output logic             zero
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sr_q;
  logic [2:0]       cmd_q;
  logic [CW-1:0]    cnt_q;
  logic             c_q;

  logic             s_res;
  logic             s_co;
  logic             last;
  logic             arith;
  logic             ov_w;
  logic             co_w;
  logic [WIDTH-1:0] full;
  logic [WIDTH-1:0] fin;

  serial_alu_slice u_slice (
    .a        (a_q[cnt_q]),
    .b        (b_q[cnt_q]),
    .carryin  (c_q),
    .command  (cmd_q),
    .result   (s_res),
    .carryout (s_co)
  );

  assign arith = is_arith(cmd_q);
  assign last  = (cnt_q == LAST);
  assign full  = {s_res, sr_q[WIDTH-1:1]};
  assign ov_w  = arith & (c_q ^ s_co);
  assign co_w  = arith & s_co;

  // SLT collapses to the corrected sign of the difference
  assign fin = (cmd_q == SLT_ALU) ?
               {{(WIDTH-1){1'b0}}, s_res ^ ov_w} :
               full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (last)  state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      sr_q     <= '0;
      cmd_q    <= '0;
      cnt_q    <= '0;
      c_q      <= 1'b0;
      result   <= '0;
      carryout <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        a_q   <= operand_a;
        b_q   <= operand_b;
        cmd_q <= command;
        cnt_q <= '0;
        c_q   <= is_sub(command);
      end
      if (state == RUN) begin
        sr_q <= full;
        if (arith) c_q <= s_co;
        if (!last) begin
          cnt_q <= cnt_q + 1'b1;
        end else begin
          result   <= fin;
          carryout <= co_w;
          overflow <= ov_w;
          zero     <= (fin == '0);
        end
      end
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule
